prog_flash_sequencer: RTL
=========================

Name: prog_flash_sequencer

Overview:
Top-level sequencer that walks a stored program image block by block. It starts program_decoder for each block and dispatches data blocks to the UPDI NVM write engine at flash-mapped addresses. It terminates on the end-of-file block, on abort, on write error, or on timeout, and reports status to the host-side control logic.

Parameters:
FLASH_BASE, 16'h8000, offset added to the block address to form the UPDI data-space address
DATA_BLOCK_MAX_SIZE, 64, maximum legal block length in bytes
WR_TIMEOUT_CYCLES, 1000000, maximum cycles allowed between wr_start and wr_done
TO_BITS, $clog2(WR_TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin programming; sampled only in IDLE
abort  in  1  stop at the next state boundary; forces FAULT with err_code 2'd0
busy  out  1  high from start acceptance until DONE or FAULT
done  out  1  level, set on EOF; cleared by the next accepted start
error  out  1  level, set on FAULT; cleared by the next accepted start
err_code  out  2  0=abort, 1=write error, 2=timeout, 3=oversize block
blocks_written  out  16  count of data blocks successfully written; saturates at 16'hFFFF
dec_start  out  1  one-cycle start pulse to program_decoder
dec_ready  in  1  decoder idle/ready
dec_done  in  1  decoder block-complete level
dec_length  in  8  decoded block length
dec_address  in  16  decoded block address
dec_type  in  8  decoded block type
wr_start  out  1  one-cycle write request pulse
wr_addr  out  16  dec_address + FLASH_BASE, modulo 2^16
wr_len  out  8  bytes to write
wr_busy  in  1  write engine busy
wr_done  in  1  one-cycle write-complete pulse
wr_error  in  1  one-cycle write-failure pulse; takes precedence over wr_done in the same cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset mid-operation returns to IDLE within one cycle, drops any pulses, and leaves no pending request.
- IDLE: on start, clear done, error, err_code and blocks_written, set busy, go to DEC_REQ. Ignore start while busy.
- DEC_REQ: wait for dec_ready=1, then pulse dec_start for exactly one cycle and go to DEC_ACK.
- DEC_ACK: wait for dec_ready=0, which is the decoder accepting the request. Go to DEC_WAIT.
- DEC_WAIT: wait for dec_done=1 and dec_ready=1. The stale done level from the previous block is masked by the DEC_ACK step. Go to DISPATCH.
- DISPATCH (one cycle), first matching rule applies:
  - type 8'h01: go to FINISH.
  - dec_length > DATA_BLOCK_MAX_SIZE: FAULT, err_code 3.
  - type 8'h00 with dec_length 0: treat as a no-op and go to DEC_REQ.
  - type 8'h00 otherwise: latch wr_addr and wr_len, go to WR_REQ.
  - Any other type: skip and go to DEC_REQ.
- WR_REQ: wait for wr_busy=0, then pulse wr_start for one cycle, clear the timeout counter, go to WR_WAIT.
- WR_WAIT: increment the timeout counter each cycle.
  - wr_error: FAULT, err_code 1.
  - wr_done: increment blocks_written (saturating), go to DEC_REQ.
  - Counter reaches WR_TIMEOUT_CYCLES: FAULT, err_code 2.
  - Precedence when events coincide: wr_error, then wr_done, then timeout.
- FINISH: set done, clear busy, go to IDLE.
- FAULT: set error, clear busy, go to IDLE.
- abort is checked in DEC_REQ, DEC_WAIT, WR_REQ and WR_WAIT only. In WR_WAIT, a coincident wr_done or wr_error wins over abort.
- Outputs are registered. dec_start and wr_start are never high for two consecutive cycles.
- Address addition wraps: with FLASH_BASE 8000, dec_address FFF0 gives wr_addr 7FF0.
- Latency from accepted start to first dec_start is at least 2 cycles.

Test Plan:
- Image of two type-00 blocks (len 16 @0000, len 8 @0010) then type-01 → wr_addr 8000/8010, wr_len 16/8, blocks_written=2, done=1, busy=0, error=0.
- Type-04 block, then type-00 len 0, then type-01 → no wr_start at all, done=1, blocks_written=0.
- Block with dec_length 65 → FAULT, err_code=3, no wr_start; a new start afterwards clears error.
- wr_error pulsed during the first write → error=1, err_code=1, blocks_written=0. Also drive wr_error and wr_done in the same cycle → err_code=1.
- wr_done withheld with WR_TIMEOUT_CYCLES=20 → error asserted exactly 20 cycles after wr_start, err_code=2.
- rst asserted in WR_WAIT, then abort asserted in DEC_WAIT on a rerun → after rst all outputs are 0 next cycle; after abort error=1, err_code=0, and no pulse is issued afterwards.

Source files
------------

// File: rtl/prog_flash_sequencer.sv
// prog_flash_sequencer
//
// Walks a stored program image one block at a time. For every block it asks
// program_decoder for the next record, then acts on the decoded type. Data
// records are sent to the UPDI NVM write engine at FLASH_BASE + address. The
// walk ends on the end-of-file record, on abort, on a write error, on a write
// timeout, or on an oversize block. Status is reported to the host-side
// control logic.
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   start, abort    : host control (start sampled only in IDLE)
//   busy            : high from start acceptance until completion or fault
//   done, error     : sticky status levels, cleared by the next accepted start
//   err_code        : 0 abort, 1 write error, 2 timeout, 3 oversize block
//   blocks_written  : data blocks successfully written (saturating)
//   dec_*           : handshake with program_decoder and its decoded fields
//   wr_*            : request/response with the UPDI NVM write engine
//
// All outputs are registered.
module prog_flash_sequencer #(
  parameter logic [15:0] FLASH_BASE          = 16'h8000,
  parameter int          DATA_BLOCK_MAX_SIZE = 64,
  parameter int          WR_TIMEOUT_CYCLES   = 1000000,
  parameter int          TO_BITS             = $clog2(WR_TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] blocks_written,
  output logic        dec_start,
  input  logic        dec_ready,
  input  logic        dec_done,
  input  logic [7:0]  dec_length,
  input  logic [15:0] dec_address,
  input  logic [7:0]  dec_type,
  output logic        wr_start,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_len,
  input  logic        wr_busy,
  input  logic        wr_done,
  input  logic        wr_error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEC_REQ,
    S_DEC_ACK,
    S_DEC_WAIT,
    S_DISPATCH,
    S_WR_REQ,
    S_WR_WAIT,
    S_FINISH,
    S_FAULT
  } state_t;

  localparam logic [7:0]         TYPE_DATA = 8'h00;
  localparam logic [7:0]         TYPE_EOF  = 8'h01;
  localparam logic [1:0]         ERR_ABORT    = 2'd0;
  localparam logic [1:0]         ERR_WRITE    = 2'd1;
  localparam logic [1:0]         ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0]         ERR_OVERSIZE = 2'd3;
  localparam logic [8:0]         MAX_LEN   = 9'(DATA_BLOCK_MAX_SIZE);
  localparam logic [TO_BITS-1:0] TO_LIMIT  = TO_BITS'(WR_TIMEOUT_CYCLES);

  state_t             state, state_nx;
  logic               busy_nx, done_nx, error_nx;
  logic [1:0]         err_code_nx;
  logic [15:0]        blocks_written_nx;
  logic               dec_start_nx, wr_start_nx;
  logic [15:0]        wr_addr_nx;
  logic [7:0]         wr_len_nx;
  logic [TO_BITS-1:0] tcount, tcount_nx, tcount_inc;

  assign tcount_inc = tcount + TO_BITS'(1);

  // State and every output live in this one register bank; reset clears all
  // of them, which also drops any pulse that was about to be issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
      blocks_written <= 16'd0;
      dec_start      <= 1'b0;
      wr_start       <= 1'b0;
      wr_addr        <= 16'd0;
      wr_len         <= 8'd0;
      tcount         <= '0;
    end else begin
      state          <= state_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      error          <= error_nx;
      err_code       <= err_code_nx;
      blocks_written <= blocks_written_nx;
      dec_start      <= dec_start_nx;
      wr_start       <= wr_start_nx;
      wr_addr        <= wr_addr_nx;
      wr_len         <= wr_len_nx;
      tcount         <= tcount_nx;
    end
  end

  // Next-state and next-output logic. Terminal transitions update the status
  // outputs as they enter FINISH/FAULT, so done/error rise together with busy
  // falling and the timeout is reported exactly WR_TIMEOUT_CYCLES after the
  // write request pulse. The pulses default low, and each is raised only on a
  // transition out of a state that cannot be re-entered on the next cycle, so
  // neither can be high two cycles running.
  always_comb begin
    state_nx          = state;
    busy_nx           = busy;
    done_nx           = done;
    error_nx          = error;
    err_code_nx       = err_code;
    blocks_written_nx = blocks_written;
    dec_start_nx      = 1'b0;
    wr_start_nx       = 1'b0;
    wr_addr_nx        = wr_addr;
    wr_len_nx         = wr_len;
    tcount_nx         = tcount;

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_nx           = 1'b1;
          done_nx           = 1'b0;
          error_nx          = 1'b0;
          err_code_nx       = 2'd0;
          blocks_written_nx = 16'd0;
          state_nx          = S_DEC_REQ;
        end
      end

      S_DEC_REQ: begin
        if (abort) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_ABORT;
          state_nx    = S_FAULT;
        end else if (dec_ready) begin
          dec_start_nx = 1'b1;
          state_nx     = S_DEC_ACK;
        end
      end

      // The decoder dropping ready is its acknowledgement; waiting for it
      // masks the done level still held from the previous block.
      S_DEC_ACK: begin
        if (!dec_ready) begin
          state_nx = S_DEC_WAIT;
        end
      end

      S_DEC_WAIT: begin
        if (abort) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_ABORT;
          state_nx    = S_FAULT;
        end else if (dec_done && dec_ready) begin
          state_nx = S_DISPATCH;
        end
      end

      // EOF is honoured before the length check, so an EOF record with a
      // large length field still finishes cleanly.
      S_DISPATCH: begin
        if (dec_type == TYPE_EOF) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_FINISH;
        end else if ({1'b0, dec_length} > MAX_LEN) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_OVERSIZE;
          state_nx    = S_FAULT;
        end else if (dec_type == TYPE_DATA) begin
          if (dec_length == 8'd0) begin
            state_nx = S_DEC_REQ;
          end else begin
            wr_addr_nx = dec_address + FLASH_BASE;
            wr_len_nx  = dec_length;
            state_nx   = S_WR_REQ;
          end
        end else begin
          state_nx = S_DEC_REQ;
        end
      end

      S_WR_REQ: begin
        if (abort) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_ABORT;
          state_nx    = S_FAULT;
        end else if (!wr_busy) begin
          wr_start_nx = 1'b1;
          tcount_nx   = '0;
          state_nx    = S_WR_WAIT;
        end
      end

      // Engine responses outrank abort, and abort outranks the timeout.
      S_WR_WAIT: begin
        tcount_nx = tcount_inc;
        if (wr_error) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_WRITE;
          state_nx    = S_FAULT;
        end else if (wr_done) begin
          if (blocks_written != 16'hFFFF) begin
            blocks_written_nx = blocks_written + 16'd1;
          end
          state_nx = S_DEC_REQ;
        end else if (abort) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_ABORT;
          state_nx    = S_FAULT;
        end else if (tcount_inc == TO_LIMIT) begin
          error_nx    = 1'b1;
          busy_nx     = 1'b0;
          err_code_nx = ERR_TIMEOUT;
          state_nx    = S_FAULT;
        end
      end

      S_FINISH: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      S_FAULT: begin
        error_nx = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
